park_pipe: RTL and testbench

Pipelined, parametrised Park / inverse-Park transform for the FOC datapath. It rotates a stationary-frame vector (alpha, beta) into the rotor frame (D, Q), or rotates back when inverse mode is selected. It uses a 3-stage registered pipeline with a valid/ready handshake and a sideband tag. It sits between the Clarke stage and the PI current loops on the forward path, and between the PI outputs and inverse Clarke/SVM on the return path. Fixed-point rounding and output saturation are included.

---
 rtl/park_pipe.sv | 140 ++++++++++++++
 tb/tb_park_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_pipe.sv
// Park / inverse-Park rotation: 3-stage pipeline (capture, multiply, combine/round/saturate)
// with a global advance enable and a sideband tag/mode carried in lockstep with each beat.
module park_pipe #(
  parameter int D_WIDTH   = 32,
  parameter int Q_BITS    = 10,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [D_WIDTH-1:0]   in_x,
  input  logic [D_WIDTH-1:0]   in_y,
  input  logic [D_WIDTH-1:0]   in_sin,
  input  logic [D_WIDTH-1:0]   in_cos,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [D_WIDTH-1:0]   out_u,
  output logic [D_WIDTH-1:0]   out_v,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_mode,
  output logic                 out_sat
);

  localparam int PW = 2 * D_WIDTH;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND   = {{(SW-1){1'b0}}, 1'b1} << (Q_BITS - 1);
  localparam logic signed [SW-1:0] MAX_V = {{(SW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  logic adv;

  logic                        s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d;
  logic [TAG_WIDTH-1:0]        s1_tag_q, s1_tag_d;
  logic signed [D_WIDTH-1:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic signed [D_WIDTH-1:0]   s1_sin_q, s1_sin_d, s1_cos_q, s1_cos_d;

  logic                        s2_valid_q, s2_valid_d, s2_mode_q, s2_mode_d;
  logic [TAG_WIDTH-1:0]        s2_tag_q, s2_tag_d;
  logic signed [PW-1:0]        s2_xc_q, s2_xc_d, s2_ys_q, s2_ys_d;
  logic signed [PW-1:0]        s2_yc_q, s2_yc_d, s2_xs_q, s2_xs_d;

  logic                        s3_valid_q, s3_valid_d, s3_mode_q, s3_mode_d;
  logic [TAG_WIDTH-1:0]        s3_tag_q, s3_tag_d;
  logic [D_WIDTH-1:0]          s3_u_q, s3_u_d, s3_v_q, s3_v_d;
  logic                        s3_sat_q, s3_sat_d;

  logic signed [SW-1:0] xc_e, ys_e, yc_e, xs_e;
  logic signed [SW-1:0] u_sum, v_sum, u_rnd, v_rnd, u_sh, v_sh;
  logic [D_WIDTH:0]     u_clip, v_clip;

  // Returns {clipped, value}; the shifted sum is still wide enough to tell overflow apart.
  function automatic logic [D_WIDTH:0] clip(input logic signed [SW-1:0] val);
    if (val > MAX_V)      clip = {1'b1, MAX_V[D_WIDTH-1:0]};
    else if (val < MIN_V) clip = {1'b1, MIN_V[D_WIDTH-1:0]};
    else                  clip = {1'b0, val[D_WIDTH-1:0]};
  endfunction

  always_comb begin
    xc_e   = {s2_xc_q[PW-1], s2_xc_q};
    ys_e   = {s2_ys_q[PW-1], s2_ys_q};
    yc_e   = {s2_yc_q[PW-1], s2_yc_q};
    xs_e   = {s2_xs_q[PW-1], s2_xs_q};
    u_sum  = s2_mode_q ? (xc_e - ys_e) : (xc_e + ys_e);
    v_sum  = s2_mode_q ? (xs_e + yc_e) : (yc_e - xs_e);
    u_rnd  = u_sum + RND;
    v_rnd  = v_sum + RND;
    u_sh   = u_rnd >>> Q_BITS;
    v_sh   = v_rnd >>> Q_BITS;
    u_clip = clip(u_sh);
    v_clip = clip(v_sh);
  end

  always_comb begin
    adv        = out_ready || !s3_valid_q;
    s1_valid_d = s1_valid_q;  s1_mode_d = s1_mode_q;  s1_tag_d = s1_tag_q;
    s1_x_d     = s1_x_q;      s1_y_d    = s1_y_q;
    s1_sin_d   = s1_sin_q;    s1_cos_d  = s1_cos_q;
    s2_valid_d = s2_valid_q;  s2_mode_d = s2_mode_q;  s2_tag_d = s2_tag_q;
    s2_xc_d    = s2_xc_q;     s2_ys_d   = s2_ys_q;
    s2_yc_d    = s2_yc_q;     s2_xs_d   = s2_xs_q;
    s3_valid_d = s3_valid_q;  s3_mode_d = s3_mode_q;  s3_tag_d = s3_tag_q;
    s3_u_d     = s3_u_q;      s3_v_d    = s3_v_q;     s3_sat_d = s3_sat_q;
    // Bubbles move with the pipe; data registers only load behind a valid beat.
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mode_d = in_mode;  s1_tag_d = in_tag;
        s1_x_d    = in_x;     s1_y_d   = in_y;
        s1_sin_d  = in_sin;   s1_cos_d = in_cos;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;  s2_tag_d = s1_tag_q;
        s2_xc_d   = s1_x_q * s1_cos_q;
        s2_ys_d   = s1_y_q * s1_sin_q;
        s2_yc_d   = s1_y_q * s1_cos_q;
        s2_xs_d   = s1_x_q * s1_sin_q;
      end
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_mode_d = s2_mode_q;  s3_tag_d = s2_tag_q;
        s3_u_d    = u_clip[D_WIDTH-1:0];
        s3_v_d    = v_clip[D_WIDTH-1:0];
        s3_sat_d  = u_clip[D_WIDTH] | v_clip[D_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;  s1_mode_q <= 1'b0;  s1_tag_q <= '0;
      s1_x_q     <= '0;    s1_y_q    <= '0;    s1_sin_q <= '0;  s1_cos_q <= '0;
      s2_valid_q <= 1'b0;  s2_mode_q <= 1'b0;  s2_tag_q <= '0;
      s2_xc_q    <= '0;    s2_ys_q   <= '0;    s2_yc_q  <= '0;  s2_xs_q  <= '0;
      s3_valid_q <= 1'b0;  s3_mode_q <= 1'b0;  s3_tag_q <= '0;
      s3_u_q     <= '0;    s3_v_q    <= '0;    s3_sat_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;  s1_mode_q <= s1_mode_d;  s1_tag_q <= s1_tag_d;
      s1_x_q     <= s1_x_d;      s1_y_q    <= s1_y_d;
      s1_sin_q   <= s1_sin_d;    s1_cos_q  <= s1_cos_d;
      s2_valid_q <= s2_valid_d;  s2_mode_q <= s2_mode_d;  s2_tag_q <= s2_tag_d;
      s2_xc_q    <= s2_xc_d;     s2_ys_q   <= s2_ys_d;
      s2_yc_q    <= s2_yc_d;     s2_xs_q   <= s2_xs_d;
      s3_valid_q <= s3_valid_d;  s3_mode_q <= s3_mode_d;  s3_tag_q <= s3_tag_d;
      s3_u_q     <= s3_u_d;      s3_v_q    <= s3_v_d;     s3_sat_q <= s3_sat_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = s3_valid_q;
  assign out_u     = s3_u_q;
  assign out_v     = s3_v_q;
  assign out_tag   = s3_tag_q;
  assign out_mode  = s3_mode_q;
  assign out_sat   = s3_sat_q;

endmodule

// File: tb/tb_park_pipe.sv
// Bench for park_pipe: directed steps plus a random sweep, checked against a
// wide-integer reference model through an in-order scoreboard.
module tb_park_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic [3:0]  in_tag = '0;
  logic [31:0] in_x = '0, in_y = '0, in_sin = '0, in_cos = '0;
  logic        out_valid, out_ready = 1'b1, out_mode, out_sat;
  logic [31:0] out_u, out_v;
  logic [3:0]  out_tag;

  logic        v16 = 1'b0, r16, m16 = 1'b0, ov16, or16 = 1'b1, om16, os16;
  logic [3:0]  t16 = '0, ot16;
  logic [15:0] x16 = '0, y16 = '0, s16 = '0, c16 = '0, ou16, ovv16;

  park_pipe #(.D_WIDTH(32), .Q_BITS(10), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_tag(in_tag), .in_x(in_x), .in_y(in_y), .in_sin(in_sin), .in_cos(in_cos),
    .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .out_v(out_v),
    .out_tag(out_tag), .out_mode(out_mode), .out_sat(out_sat));

  park_pipe #(.D_WIDTH(16), .Q_BITS(10), .TAG_WIDTH(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_mode(m16),
    .in_tag(t16), .in_x(x16), .in_y(y16), .in_sin(s16), .in_cos(c16),
    .out_valid(ov16), .out_ready(or16), .out_u(ou16), .out_v(ovv16),
    .out_tag(ot16), .out_mode(om16), .out_sat(os16));

  typedef struct {
    logic [31:0] u;
    logic [31:0] v;
    logic [3:0]  tag;
    logic        mode;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0, n_acc = 0, n_out = 0;
  bit   acc_n = 1'b0, stall_prev = 1'b0;
  logic [31:0] h_u, h_v;
  logic [3:0]  h_tag;
  logic        h_mode, h_sat;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // D_WIDTH=32, Q_BITS=10 reference in 128-bit arithmetic.
  function automatic exp_t ref_park(input logic m, input logic [3:0] tag,
                                    input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] s, input logic [31:0] c);
    logic signed [127:0] xx, yy, ss, cc, su, sv, maxv, minv;
    exp_t r;
    xx = $signed(x);  yy = $signed(y);  ss = $signed(s);  cc = $signed(c);
    maxv = (128'sd1 <<< 31) - 128'sd1;
    minv = -(128'sd1 <<< 31);
    su = m ? (xx * cc - yy * ss) : (xx * cc + yy * ss);
    sv = m ? (xx * ss + yy * cc) : (yy * cc - xx * ss);
    su = (su + 128'sd512) >>> 10;
    sv = (sv + 128'sd512) >>> 10;
    r.sat = 1'b0;
    if (su > maxv) begin su = maxv; r.sat = 1'b1; end
    if (su < minv) begin su = minv; r.sat = 1'b1; end
    if (sv > maxv) begin sv = maxv; r.sat = 1'b1; end
    if (sv < minv) begin sv = minv; r.sat = 1'b1; end
    r.u = su[31:0];  r.v = sv[31:0];  r.tag = tag;  r.mode = m;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_n = 1'b0;
      stall_prev = 1'b0;
    end else begin
      acc_n = in_valid && in_ready;
      if (acc_n) begin
        sb.push_back(ref_park(in_mode, in_tag, in_x, in_y, in_sin, in_cos));
        n_acc++;
      end
      if (stall_prev) begin
        check("hold_u", out_u, h_u);
        check("hold_v", out_v, h_v);
        check("hold_tag", 32'(out_tag), 32'(h_tag));
        check("hold_mode", 32'(out_mode), 32'(h_mode));
        check("hold_sat", 32'(out_sat), 32'(h_sat));
      end
      if (out_valid && out_ready) begin
        n_tests++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_empty: observed output tag %0h expected no output", out_tag);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_u", out_u, e.u);
          check("out_v", out_v, e.v);
          check("out_tag", 32'(out_tag), 32'(e.tag));
          check("out_mode", 32'(out_mode), 32'(e.mode));
          check("out_sat", 32'(out_sat), 32'(e.sat));
        end
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      h_u = out_u;  h_v = out_v;  h_tag = out_tag;  h_mode = out_mode;  h_sat = out_sat;
    end
  end

  task automatic set_beat(input logic m, input logic [3:0] t, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] s, input logic [31:0] c);
    in_mode = m;  in_tag = t;  in_x = x;  in_y = y;  in_sin = s;  in_cos = c;
    in_valid = 1'b1;
  endtask

  // Sends one beat into an idle pipe; lat = cycles from the accept cycle to out_valid.
  task automatic send_one(input logic m, input logic [3:0] t, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] s, input logic [31:0] c,
                          output int lat);
    @(posedge clk); #1;
    set_beat(m, t, x, y, s, c);
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rand_beat();
    logic [31:0] x, y, s, c;
    x = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(0, 200000)) - 32'd100000;
    y = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(0, 200000)) - 32'd100000;
    case ($urandom_range(0, 9))
      0: s = 32'h8000_0000;
      1: s = 32'($urandom);
      default: s = 32'($urandom_range(0, 2048)) - 32'd1024;
    endcase
    case ($urandom_range(0, 9))
      0: c = 32'h8000_0000;
      1: x = 32'h8000_0000;
      default: c = 32'($urandom_range(0, 2048)) - 32'd1024;
    endcase
    if ($urandom_range(0, 19) == 0) begin x = 32'h8000_0000; y = 32'h8000_0000; end
    set_beat(1'($urandom_range(0, 1)), 4'($urandom), x, y, s, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w, sent, guard;

    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_u", out_u, 0);
    check("rst_out_v", out_v, 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_out_mode", 32'(out_mode), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Forward reference beat
    send_one(1'b0, 4'd3, 32'd40, 32'd32, 32'd886, 32'd512, lat);
    check("fwd_latency", 32'(lat), 3);
    check("fwd_u", out_u, 32'd48);
    check("fwd_v", out_v, -32'sd19);
    check("fwd_tag", 32'(out_tag), 3);
    check("fwd_sat", 32'(out_sat), 0);

    // Inverse reference beat
    send_one(1'b1, 4'd9, 32'd48, -32'sd19, 32'd886, 32'd512, lat);
    check("inv_latency", 32'(lat), 3);
    check("inv_u", out_u, 32'd40);
    check("inv_v", out_v, 32'd32);
    check("inv_mode", 32'(out_mode), 1);

    // Saturation on the 16-bit instance
    @(posedge clk); #1;
    x16 = 16'h7FFF;  y16 = 16'h7FFF;  s16 = 16'd1024;  c16 = 16'd1024;  m16 = 1'b0;  t16 = 4'd5;
    v16 = 1'b1;
    @(negedge clk);
    check("sat16_in_ready", 32'(r16), 1);
    @(posedge clk); #1;
    v16 = 1'b0;
    w = 0;
    while (!ov16 && w < 10) begin @(negedge clk); w++; end
    check("sat16_latency", 32'(w), 3);
    check("sat16_u", 32'(ou16), 32'h7FFF);
    check("sat16_v", 32'(ovv16), 0);
    check("sat16_sat", 32'(os16), 1);
    check("sat16_tag", 32'(ot16), 5);

    // Streaming: 6 mixed beats, 4-cycle stall after the first result
    repeat (3) @(posedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int wt;
          @(posedge clk); #1;
          set_beat(1'(i % 2), 4'(i), 32'(100 * i - 200), 32'(37 * i + 5),
                   32'(886 - 150 * i), 32'(512 + 60 * i));
          wt = 0;
          @(negedge clk);
          while (!in_ready && wt < 20) begin @(negedge clk); wt++; end
          check("stream_accept", 32'(wt < 20), 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        int ws;
        ws = 0;
        @(negedge clk);
        while (!out_valid && ws < 20) begin @(negedge clk); ws++; end
        check("stream_first_out", 32'(ws < 20), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 0);
          check("stall_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (sb.size() != 0 && w < 30) begin @(negedge clk); w++; end
    check("stream_drained", 32'(sb.size()), 0);

    // Reset with two beats in flight (one on the outputs, one in S2)
    @(posedge clk); #1;
    set_beat(1'b0, 4'd7, 32'd1000, 32'd2000, 32'd300, 32'd900);
    @(posedge clk); #1;
    set_beat(1'b1, 4'd8, 32'd1500, -32'sd700, 32'd400, 32'd800);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_u", out_u, 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(out_valid), 0);
    end
    send_one(1'b0, 4'd2, 32'd1000, 32'd2000, 32'd300, 32'd900, lat);
    check("post_rst_latency", 32'(lat), 3);
    check("post_rst_tag", 32'(out_tag), 2);
    w = 0;
    while (sb.size() != 0 && w < 10) begin @(negedge clk); w++; end

    // Random sweep with random backpressure
    n_acc = 0;
    n_out = 0;
    sent = 0;
    guard = 0;
    while ((sent < 1000 || in_valid) && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (in_valid && acc_n) sent++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_n) begin
        if (sent < 1000 && $urandom_range(0, 4) != 0) rand_beat();
        else in_valid = 1'b0;
      end
    end
    check("sweep_guard", 32'(guard < 20000), 1);
    check("sweep_sent", 32'(sent), 1000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 50) begin @(negedge clk); w++; end
    check("sweep_drained", 32'(sb.size()), 0);
    check("sweep_count", 32'(n_out), 32'(n_acc));
    check("sweep_acc", 32'(n_acc), 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
